// File: rtl/obsluga_przelacznikow_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pkg_sterownik
// Brief    : Shared state encoding, timing constants and width helpers for
//            the switch front-end.
// Revision : 1.0 - initial release
// ============================================================================
package pkg_sterownik;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_REPEAT_UP   = 2'd1,
        ST_REPEAT_DOWN = 2'd2,
        ST_LOCK        = 2'd3
    } stan_t;

    // Board timing at 50 MHz
    localparam int unsigned c_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned c_REPEAT_DELAY    = 25000000;
    localparam int unsigned c_REPEAT_PERIOD   = 10000000;

    // Shortened values for simulation
    localparam int unsigned c_SIM_DEBOUNCE_CYCLES = 4;
    localparam int unsigned c_SIM_REPEAT_DELAY    = 20;
    localparam int unsigned c_SIM_REPEAT_PERIOD   = 8;

    // Bit positions of the switches in the packed vectors
    localparam int c_IDX_SW2 = 0;
    localparam int c_IDX_SW5 = 1;
    localparam int c_IDX_SW6 = 2;

    function automatic int unsigned licznik_szer(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/obsluga_przelacznikow_filtr.sv
`default_nettype none
// ============================================================================
// Module   : filtr_drgan_styku
// Brief    : Two-flop synchroniser, debounce counter and press-edge flag for
//            one active-low switch.
// Revision : 1.0 - initial release
// ============================================================================
module filtr_drgan_styku
    import pkg_sterownik::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic switch_n,
    output logic stable_level,
    output logic press_edge,
    output logic quiet
);

    localparam int unsigned            c_CNT_W    = licznik_szer(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0]     c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync_1;
    logic               r_sync_2;
    logic               r_stable;
    logic               r_press;
    logic [1:0]         r_primed;
    logic [c_CNT_W-1:0] r_cnt;

    logic w_mismatch;
    logic w_flip;

    assign w_mismatch = (r_sync_2 != r_stable);
    assign w_flip     = w_mismatch && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_1 <= 1'b1;
            r_sync_2 <= 1'b1;
            r_stable <= 1'b1;
            r_press  <= 1'b0;
            r_primed <= 2'b00;
            r_cnt    <= '0;
        end else begin
            r_sync_1 <= switch_n;
            r_sync_2 <= r_sync_1;
            r_primed <= {r_primed[0], 1'b1};
            r_press  <= w_flip && r_stable;
            if (w_flip) begin
                r_stable <= r_sync_2;
                r_cnt    <= '0;
            end else if (w_mismatch) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign stable_level = r_stable;
    assign press_edge   = r_press;
    // Quiet only once the synchroniser holds real samples that agree with the
    // stable level, so a key held through reset is not mistaken for released.
    assign quiet        = r_primed[1] && !w_mismatch;

endmodule
`default_nettype wire

// File: rtl/obsluga_przelacznikow.sv
`default_nettype none
// ============================================================================
// Module   : obsluga_przelacznikow
// Brief    : Debounces the three board switches and decodes them into
//            single-cycle RPM / start / stop commands with auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module obsluga_przelacznikow
    import pkg_sterownik::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = c_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = c_REPEAT_PERIOD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       switch_2,
    input  logic       switch_5,
    input  logic       switch_6,
    output logic       zwieksz_rpm,
    output logic       zmniejsz_rpm,
    output logic       zadanie_rozruchu,
    output logic       zatrzymanie,
    output logic [2:0] przycisniete
);

    localparam int unsigned        c_RPT_W       = licznik_szer(max_u(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [c_RPT_W-1:0] c_DELAY_LAST  = c_RPT_W'(REPEAT_DELAY - 1);
    localparam logic [c_RPT_W-1:0] c_PERIOD_LAST = c_RPT_W'(REPEAT_PERIOD - 1);

    logic [2:0] w_raw;
    logic [2:0] w_stable;
    logic [2:0] w_edge;
    logic [2:0] w_quiet;
    logic [2:0] w_wcisniete;

    assign w_raw = {switch_6, switch_5, switch_2};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_filtr
            filtr_drgan_styku #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_filtr (
                .clk          (clk),
                .rst          (rst),
                .switch_n     (w_raw[gi]),
                .stable_level (w_stable[gi]),
                .press_edge   (w_edge[gi]),
                .quiet        (w_quiet[gi])
            );
        end
    endgenerate

    assign w_wcisniete  = ~w_stable;
    assign przycisniete = w_wcisniete;

    stan_t              r_stan;
    logic [c_RPT_W-1:0] r_rpt_cnt;
    logic               r_pierwszy;
    logic               r_zwieksz;
    logic               r_zmniejsz;
    logic               r_rozruch;
    logic               r_stop;

    logic               w_own;
    logic               w_other;
    logic [c_RPT_W-1:0] w_rpt_last;

    // Owning key and "any other key" for whichever repeat state is active
    always_comb begin
        w_own   = 1'b0;
        w_other = 1'b0;
        if (r_stan == ST_REPEAT_UP) begin
            w_own   = w_wcisniete[c_IDX_SW6];
            w_other = w_wcisniete[c_IDX_SW2] | w_wcisniete[c_IDX_SW5];
        end else begin
            w_own   = w_wcisniete[c_IDX_SW5];
            w_other = w_wcisniete[c_IDX_SW2] | w_wcisniete[c_IDX_SW6];
        end
    end

    assign w_rpt_last = r_pierwszy ? c_DELAY_LAST : c_PERIOD_LAST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stan     <= ST_LOCK;
            r_rpt_cnt  <= '0;
            r_pierwszy <= 1'b1;
            r_zwieksz  <= 1'b0;
            r_zmniejsz <= 1'b0;
            r_rozruch  <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            r_zwieksz  <= 1'b0;
            r_zmniejsz <= 1'b0;
            r_rozruch  <= 1'b0;
            r_stop     <= 1'b0;
            case (r_stan)
                ST_IDLE: begin
                    if (w_edge[c_IDX_SW5] && w_edge[c_IDX_SW6]) begin
                        r_stan <= ST_LOCK;
                    end else if (w_edge[c_IDX_SW6] && w_wcisniete[c_IDX_SW2]) begin
                        r_rozruch <= 1'b1;
                        r_stan    <= ST_LOCK;
                    end else if (w_edge[c_IDX_SW5] && w_wcisniete[c_IDX_SW2]) begin
                        r_stop <= 1'b1;
                        r_stan <= ST_LOCK;
                    end else if (w_edge[c_IDX_SW6]) begin
                        r_zwieksz  <= 1'b1;
                        r_stan     <= ST_REPEAT_UP;
                        r_rpt_cnt  <= '0;
                        r_pierwszy <= 1'b1;
                    end else if (w_edge[c_IDX_SW5]) begin
                        r_zmniejsz <= 1'b1;
                        r_stan     <= ST_REPEAT_DOWN;
                        r_rpt_cnt  <= '0;
                        r_pierwszy <= 1'b1;
                    end else if (w_edge[c_IDX_SW2]) begin
                        r_stan <= ST_IDLE;
                    end
                end
                ST_REPEAT_UP, ST_REPEAT_DOWN: begin
                    // Leaving the state always beats a due repeat pulse
                    if (w_other) begin
                        r_stan <= ST_LOCK;
                    end else if (!w_own) begin
                        r_stan <= ST_IDLE;
                    end else if (r_rpt_cnt == w_rpt_last) begin
                        if (r_stan == ST_REPEAT_UP) begin
                            r_zwieksz <= 1'b1;
                        end else begin
                            r_zmniejsz <= 1'b1;
                        end
                        r_rpt_cnt  <= '0;
                        r_pierwszy <= 1'b0;
                    end else begin
                        r_rpt_cnt <= r_rpt_cnt + 1'b1;
                    end
                end
                ST_LOCK: begin
                    if ((&w_stable) && (&w_quiet)) begin
                        r_stan <= ST_IDLE;
                    end
                end
                default: begin
                    r_stan <= ST_LOCK;
                end
            endcase
        end
    end

    assign zwieksz_rpm      = r_zwieksz;
    assign zmniejsz_rpm     = r_zmniejsz;
    assign zadanie_rozruchu = r_rozruch;
    assign zatrzymanie      = r_stop;

endmodule
`default_nettype wire

// File: doc/obsluga_przelacznikow.md
Name: obsluga_przelacznikow

Overview:
- Front-end stage that cleans the raw board switches before they reach glowny_sterownik_silnika.
- Synchronises and debounces switch_2, switch_5 and switch_6, which are active-low (released = 1).
- Decodes them into single-cycle commands: RPM up, RPM down, start (rozruch request) and stop.
- Provides auto-repeat on held RPM keys, and a lockout that stops ambiguous combinations from producing commands.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable samples needed to accept a level change (10 ms at 50 MHz).
- REPEAT_DELAY, 25000000: cycles from the first pulse of a held key to its first repeat pulse.
- REPEAT_PERIOD, 10000000: cycles between subsequent repeat pulses.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- switch_2  in  1  raw modifier switch, active-low.
- switch_5  in  1  raw "down/stop" switch, active-low.
- switch_6  in  1  raw "up/start" switch, active-low.
- zwieksz_rpm  out  1  one-cycle pulse: increase RPM.
- zmniejsz_rpm  out  1  one-cycle pulse: decrease RPM.
- zadanie_rozruchu  out  1  one-cycle pulse: start request.
- zatrzymanie  out  1  one-cycle pulse: stop request.
- przycisniete  out  3  debounced pressed levels, active-high; bit0 = switch_2, bit1 = switch_5, bit2 = switch_6.

Behaviour:
- Reset (asynchronous):
  - All pulse outputs = 0 and przycisniete = 3'b000.
  - Synchroniser flops and debounced stable levels = 1 (released); debounce and repeat counters = 0.
  - FSM = LOCK.
- Synchroniser: 2 flops per switch.
- Debounce, per switch:
  - The counter increments while the synchronised level differs from the stable level, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still mismatched, the stable level flips and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES).
- Press edge: stable level goes 1->0. A command pulse is registered in the cycle after the press edge.
- Total latency from a raw level that stays settled to its pulse: DEBOUNCE_CYCLES+3 clock edges.
- FSM states: IDLE, REPEAT_UP, REPEAT_DOWN, LOCK.
- IDLE, checked in priority order:
  - Press edges of switch_5 and switch_6 in the same cycle: no pulse, go to LOCK.
  - switch_6 edge while switch_2 pressed: zadanie_rozruchu, go to LOCK.
  - switch_5 edge while switch_2 pressed: zatrzymanie, go to LOCK.
  - switch_6 edge alone: zwieksz_rpm, go to REPEAT_UP, repeat counter = 0.
  - switch_5 edge alone: zmniejsz_rpm, go to REPEAT_DOWN, repeat counter = 0.
  - switch_2 edge alone: no pulse, stay in IDLE.
- REPEAT_UP / REPEAT_DOWN:
  - The repeat counter increments every cycle.
  - The first repeat pulse fires when the counter reaches REPEAT_DELAY-1. After that, a pulse fires every REPEAT_PERIOD cycles; the counter reloads on each pulse.
  - Owning key released, no other key pressed: go to IDLE, no pulse.
  - Any other key pressed while the owning key is still held: go to LOCK; no pulse in that cycle.
- LOCK: all pulses 0. Go to IDLE in the cycle after all three stable levels read released.
- At most one pulse output is high in any cycle.
- przycisniete = inverted stable levels; no additional latency.
- Repeat counter width: $clog2 of max(REPEAT_DELAY, REPEAT_PERIOD).
- Reset mid-hold: the FSM restarts in LOCK, so a key held through reset produces no command until it is released.

Decomposition:
- Shared package (pkg_sterownik):
  - FSM state encoding (2-bit typedef).
  - Default timing constants DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD.
  - Reduced simulation values: 4 / 20 / 8.
- Sub-module filtr_drgan_styku (synchroniser + debounce counter + press-edge output), parameterised by DEBOUNCE_CYCLES and instantiated 3 times.
- FSM and repeat counter live in the top module.

Test Plan (parameters 4/20/8):
- Bounce test:
  - Stimulus: switch_6 toggles every 2 cycles for 20 cycles, then held at 0.
  - Response: exactly one zwieksz_rpm pulse, 7 clocks after the final raw edge; no pulses during the bounce.
- Auto-repeat:
  - Stimulus: hold switch_5 for 60 cycles after its first pulse at t0.
  - Response: zmniejsz_rpm pulses at t0, t0+20, t0+28, t0+36, t0+44, t0+52 (6 pulses); none after release.
- Start combination:
  - Stimulus: switch_2=0, switch_6=0 10 cycles later, held 1000 cycles, then both set to 1.
  - Response: exactly one zadanie_rozruchu pulse, zero zwieksz_rpm pulses, FSM returns to IDLE.
- Stop combination:
  - Stimulus: switch_2 held, then switch_5 pressed.
  - Response: one zatrzymanie pulse, no zmniejsz_rpm pulse.
- Simultaneous presses:
  - Stimulus: switch_5 and switch_6 fall in the same cycle; both released; then switch_6 pressed alone.
  - Response: no pulse for the simultaneous press, then exactly one zwieksz_rpm pulse.
- Reset mid-repeat:
  - Stimulus: assert rst while in REPEAT_UP with switch_6 held.
  - Response: all outputs 0 immediately, without waiting for a clock. After deassertion, no pulse until switch_6 is released and pressed again; the new press gives one pulse.
